xor_2x1: RTL and testbench



---
 rtl/xor_2x1.sv | 94 +++++++++
 tb/tb_xor_2x1.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/xor_2x1.sv
// xor_2x1: bitwise two-input XOR datapath primitive.
// Provides a zero-latency combinational result (out, any_diff) plus a
// valid-qualified registered copy (out_q, out_valid, parity) and a
// saturating count of accepted cycles whose XOR result was nonzero.
// Optional feature macro: XOR_2X1_HAMMING_EN -- when defined, ham_q carries
// the popcount of the captured XOR result; otherwise ham_q is tied to 0
// and no popcount logic exists.
module xor_2x1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16,
  localparam int HAM_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic             parity,
  output logic             any_diff,
  output logic [CNT_W-1:0] diff_cnt,
  output logic [HAM_W-1:0] ham_q
);

  // A zero-width datapath is meaningless; stop elaboration early.
  if (WIDTH < 1) begin : g_bad_width
    $error("xor_2x1: WIDTH must be at least 1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] xor_val;

  // Zero-latency difference; no dependence on clock, reset or valid.
  always_comb begin
    xor_val  = in0 ^ in1;
    out      = xor_val;
    any_diff = |xor_val;
  end

  // Capture the XOR result on accepted cycles; reset discards any pending capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= xor_val;
      end
    end
  end

  // Parity follows out_q directly, so it moves in step with the registered result.
  always_comb begin
    parity = ^out_q;
  end

  // Count accepted cycles with a nonzero difference, sticking at the maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_cnt <= '0;
    end else if (in_valid && any_diff && (diff_cnt != CNT_MAX)) begin
      diff_cnt <= diff_cnt + CNT_W'(1);
    end
  end

`ifdef XOR_2X1_HAMMING_EN
  logic [HAM_W-1:0] pop_cnt;

  // Population count of the current XOR result.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_cnt = pop_cnt + HAM_W'(xor_val[i]);
    end
  end

  // Register the popcount alongside out_q so both describe the same capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ham_q <= '0;
    end else if (in_valid) begin
      ham_q <= pop_cnt;
    end
  end
`else
  // Port kept for interface stability; no popcount hardware when disabled.
  assign ham_q = '0;
`endif

endmodule

// File: tb/tb_xor_2x1.sv
// tb_xor_2x1: directed self-checking bench for xor_2x1.
// Three instances share one clock: a WIDTH=1 default unit, a WIDTH=1 unit
// with a 2-bit counter for saturation, and a WIDTH=8 unit for the wide
// datapath and the optional Hamming output (XOR_2X1_HAMMING_EN).
module tb_xor_2x1;

  logic clk = 1'b0;

  // Clock generation, period 10.
  always #5 clk = ~clk;

  // Instance a: WIDTH=1, CNT_W=16
  logic       rst_a, v_a;
  logic [0:0] a0, a1, out_a, outq_a, ham_a;
  logic       ov_a, par_a, any_a;
  logic [15:0] cnt_a;

  // Instance s: WIDTH=1, CNT_W=2
  logic       rst_s, v_s;
  logic [0:0] s0, s1, out_s, outq_s, ham_s;
  logic       ov_s, par_s, any_s;
  logic [1:0] cnt_s;

  // Instance w: WIDTH=8, CNT_W=16
  logic       rst_w, v_w;
  logic [7:0] w0, w1, out_w, outq_w;
  logic [3:0] ham_w;
  logic       ov_w, par_w, any_w;
  logic [15:0] cnt_w;

  int testsRun = 0;
  int testsFailed = 0;

  xor_2x1 #(.WIDTH(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst_a), .in0(a0), .in1(a1), .in_valid(v_a),
    .out(out_a), .out_q(outq_a), .out_valid(ov_a), .parity(par_a),
    .any_diff(any_a), .diff_cnt(cnt_a), .ham_q(ham_a)
  );

  xor_2x1 #(.WIDTH(1), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst_s), .in0(s0), .in1(s1), .in_valid(v_s),
    .out(out_s), .out_q(outq_s), .out_valid(ov_s), .parity(par_s),
    .any_diff(any_s), .diff_cnt(cnt_s), .ham_q(ham_s)
  );

  xor_2x1 #(.WIDTH(8), .CNT_W(16)) dut_w (
    .clk(clk), .rst(rst_w), .in0(w0), .in1(w1), .in_valid(v_w),
    .out(out_w), .out_q(outq_w), .out_valid(ov_w), .parity(par_w),
    .any_diff(any_w), .diff_cnt(cnt_w), .ham_q(ham_w)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] vecs [4];
  logic       expOut [4];
  logic [3:0] expHam1, expHam2;

  initial begin
    rst_a = 1'b0; v_a = 1'b0; a0 = 1'b0; a1 = 1'b0;
    rst_s = 1'b1; v_s = 1'b0; s0 = 1'b0; s1 = 1'b0;
    rst_w = 1'b1; v_w = 1'b0; w0 = 8'h00; w1 = 8'h00;

    // Combinational truth table, changes every 10 time units.
    vecs[0] = 2'b00; expOut[0] = 1'b0;
    vecs[1] = 2'b10; expOut[1] = 1'b1;
    vecs[2] = 2'b01; expOut[2] = 1'b1;
    vecs[3] = 2'b11; expOut[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a0 = vecs[i][1];
      a1 = vecs[i][0];
      #1;
      checkOutput($sformatf("comb_out_%0d", i), 32'(out_a), 32'(expOut[i]));
      checkOutput($sformatf("comb_any_%0d", i), 32'(any_a), 32'(expOut[i]));
      #9;
    end

    // Reset for two edges.
    rst_a = 1'b1; v_a = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_outq",   32'(outq_a), 32'd0);
    checkOutput("rst_ovalid", 32'(ov_a),   32'd0);
    checkOutput("rst_parity", 32'(par_a),  32'd0);
    checkOutput("rst_cnt",    32'(cnt_a),  32'd0);
    checkOutput("rst_ham",    32'(ham_a),  32'd0);

    // First accepted difference.
    rst_a = 1'b0; v_a = 1'b1; a0 = 1'b1; a1 = 1'b0;
    applyStimulus();
    checkOutput("cap_outq",   32'(outq_a), 32'd1);
    checkOutput("cap_ovalid", 32'(ov_a),   32'd1);
    checkOutput("cap_parity", 32'(par_a),  32'd1);
    checkOutput("cap_cnt",    32'(cnt_a),  32'd1);

    // Hold with in_valid low.
    v_a = 1'b0; a0 = 1'b1; a1 = 1'b1;
    #1;
    checkOutput("hold_out", 32'(out_a), 32'd0);
    checkOutput("hold_any", 32'(any_a), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("hold_outq_%0d", i),   32'(outq_a), 32'd1);
      checkOutput($sformatf("hold_ovalid_%0d", i), 32'(ov_a),   32'd0);
      checkOutput($sformatf("hold_cnt_%0d", i),    32'(cnt_a),  32'd1);
    end

    // Reset wins over a simultaneous valid capture.
    rst_a = 1'b1; v_a = 1'b1; a0 = 1'b1; a1 = 1'b0;
    applyStimulus();
    checkOutput("midrst_outq",   32'(outq_a), 32'd0);
    checkOutput("midrst_ovalid", 32'(ov_a),   32'd0);
    checkOutput("midrst_cnt",    32'(cnt_a),  32'd0);
    checkOutput("midrst_out",    32'(out_a),  32'd1);

    // Accepted zero result: captured but not counted.
    rst_a = 1'b0; v_a = 1'b1; a0 = 1'b1; a1 = 1'b1;
    applyStimulus();
    checkOutput("zero_outq",   32'(outq_a), 32'd0);
    checkOutput("zero_ovalid", 32'(ov_a),   32'd1);
    checkOutput("zero_cnt",    32'(cnt_a),  32'd0);
    v_a = 1'b0;

    // Saturation with a 2-bit counter: 1, 2, 3, 3, 3.
    applyStimulus();
    rst_s = 1'b0; v_s = 1'b1; s0 = 1'b1; s1 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus();
      checkOutput($sformatf("sat_cnt_%0d", k), 32'(cnt_s), (k < 3) ? 32'(k) : 32'd3);
    end
    v_s = 1'b0;

    // Wide datapath and optional popcount.
`ifdef XOR_2X1_HAMMING_EN
    expHam1 = 4'd4;
    expHam2 = 4'd7;
`else
    expHam1 = 4'd0;
    expHam2 = 4'd0;
`endif
    rst_w = 1'b0; v_w = 1'b1; w0 = 8'hF0; w1 = 8'h3C;
    #1;
    checkOutput("w_out", 32'(out_w), 32'h0000_00CC);
    checkOutput("w_any", 32'(any_w), 32'd1);
    applyStimulus();
    checkOutput("w_outq",   32'(outq_w), 32'h0000_00CC);
    checkOutput("w_parity", 32'(par_w),  32'd0);
    checkOutput("w_ham",    32'(ham_w),  32'(expHam1));
    checkOutput("w_cnt",    32'(cnt_w),  32'd1);

    v_w = 1'b0; w0 = 8'h00; w1 = 8'h00;
    applyStimulus();
    checkOutput("w_hold_outq",   32'(outq_w), 32'h0000_00CC);
    checkOutput("w_hold_ham",    32'(ham_w),  32'(expHam1));
    checkOutput("w_hold_ovalid", 32'(ov_w),   32'd0);
    checkOutput("w_any_zero",    32'(any_w),  32'd0);

    v_w = 1'b1; w0 = 8'hFF; w1 = 8'h01;
    applyStimulus();
    checkOutput("w2_outq",   32'(outq_w), 32'h0000_00FE);
    checkOutput("w2_parity", 32'(par_w),  32'd1);
    checkOutput("w2_ham",    32'(ham_w),  32'(expHam2));
    checkOutput("w2_cnt",    32'(cnt_w),  32'd2);
    v_w = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
